// File: rtl/spi_slave_byte_if.sv
// User-side byte interface of spi_slave_byte: transmit holding-register load and receive strobe.
interface spi_slave_byte_if;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;

  modport slave (
    input  tx_byte, tx_byte_valid,
    output tx_ready, tx_underrun, rx_byte, rx_byte_valid
  );

  modport master (
    output tx_byte, tx_byte_valid,
    input  tx_ready, tx_underrun, rx_byte, rx_byte_valid
  );
endinterface

// File: rtl/spi_slave_byte.sv
// SPI mode-0 MSB-first byte slave: oversampled sck/cs_n/mosi, deserialises MOSI and
// serialises a holding-register byte (or 0x00 on underrun) onto MISO in the same frame.
module spi_slave_byte #(
  parameter int unsigned SYS_FREQ    = 100_000_000,
  parameter int unsigned SCK_FREQ    = 25_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sck_i,
  input  logic                     cs_n_i,
  input  logic                     mosi_i,
  output logic                     miso_o,
  spi_slave_byte_if.slave          usr
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  if (SYS_FREQ < 4 * SCK_FREQ) begin : g_bad_freq
    $error("spi_slave_byte: SYS_FREQ must be at least 4*SCK_FREQ");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_slave_byte: SYNC_STAGES must be at least 2");
  end

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_d1_q, cs_d1_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0]   rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0]   hold_q, hold_d;
  logic                tx_ready_q, tx_ready_d;
  logic                slot_loaded_q, slot_loaded_d;
  logic                miso_q, miso_d;
  logic [BYTE_W-1:0]   rx_byte_q, rx_byte_d;
  logic                rx_valid_q, rx_valid_d;
  logic                underrun_q, underrun_d;
  logic                slot_load_c;
  logic [BYTE_W-1:0]   slot_byte_c;

  // Input synchronisers, preset to the idle bus (sck=0, cs_n=1, mosi=0)
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_d1_q    <= 1'b0;
      cs_d1_q     <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sck_d1_q    <= sck_s;
      cs_d1_q     <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d1_q;
  assign sck_fall = ~sck_s & sck_d1_q;
  assign cs_fall  = ~cs_s & cs_d1_q;

  // An empty holding register yields a 0x00 slot
  assign slot_byte_c = tx_ready_q ? '0 : hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      hold_q        <= '0;
      tx_ready_q    <= 1'b1;
      slot_loaded_q <= 1'b0;
      miso_q        <= 1'b0;
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      hold_q        <= hold_d;
      tx_ready_q    <= tx_ready_d;
      slot_loaded_q <= slot_loaded_d;
      miso_q        <= miso_d;
      rx_byte_q     <= rx_byte_d;
      rx_valid_q    <= rx_valid_d;
      underrun_q    <= underrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    hold_d        = hold_q;
    tx_ready_d    = tx_ready_q;
    slot_loaded_d = slot_loaded_q;
    miso_d        = miso_q;
    rx_byte_d     = rx_byte_q;
    rx_valid_d    = 1'b0;
    underrun_d    = 1'b0;
    slot_load_c   = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d        = 1'b0;
        bit_cnt_d     = '0;
        slot_loaded_d = 1'b0;
        if (cs_fall) begin
          state_d     = ACTIVE;
          slot_load_c = 1'b1;
          miso_d      = slot_byte_c[BYTE_W-1];
          tx_shift_d  = {slot_byte_c[BYTE_W-2:0], 1'b0};
        end
      end
      ACTIVE: begin
        // Deselect beats any simultaneous sck edge
        if (cs_s) begin
          state_d       = IDLE;
          miso_d        = 1'b0;
          bit_cnt_d     = '0;
          slot_loaded_d = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
            rx_byte_d     = {rx_shift_q[BYTE_W-2:0], mosi_s};
            rx_valid_d    = 1'b1;
            slot_load_c   = 1'b1;
            tx_shift_d    = slot_byte_c;
            slot_loaded_d = 1'b1;
          end
        end else if (sck_fall) begin
          // The fall before the first rise of a frame has nothing new to shift
          if (bit_cnt_q != '0 || slot_loaded_q) begin
            miso_d     = tx_shift_q[BYTE_W-1];
            tx_shift_d = {tx_shift_q[BYTE_W-2:0], 1'b0};
          end
          slot_loaded_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (slot_load_c) begin
      underrun_d = tx_ready_q;
      tx_ready_d = 1'b1;
    end
    // Accept only into an empty register, so it never collides with a consume
    if (usr.tx_byte_valid && tx_ready_q) begin
      hold_d     = usr.tx_byte;
      tx_ready_d = 1'b0;
    end
  end

  assign miso_o            = miso_q;
  assign usr.tx_ready      = tx_ready_q;
  assign usr.tx_underrun   = underrun_q;
  assign usr.rx_byte       = rx_byte_q;
  assign usr.rx_byte_valid = rx_valid_q;

endmodule
